// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the single register-file write port (wa3/wd3/we3) between two
// requesters using a registered req/gnt handshake. It also runs a clear
// sequence that zeroes every register after reset or when clr_req is seen.
// Optional build macro: REGFILE_ARB_ROUND_ROBIN_EN selects round-robin
// tie-breaking. Without it, requester 0 wins ties (fixed priority).
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_CLEAR | writing zero to address cnt_q on every edge, grants held off
// ST_ARB   | arbitrating req0/req1 on every edge, clr_req restarts a clear
module regfile_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt1,
  input  logic              clr_req,
  output logic              busy,
  output logic [ADDR_W-1:0] wa3,
  output logic [DATA_W-1:0] wd3,
  output logic              we3
);

  typedef enum logic {ST_CLEAR, ST_ARB} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              we3_q, we3_d;
  logic [ADDR_W-1:0] wa3_q, wa3_d;
  logic [DATA_W-1:0] wd3_q, wd3_d;

  logic elig0, elig1, pick0, pick1;

  // A requester granted on the previous edge is masked for one cycle so it
  // is never granted twice before it can drop or change its request.
  assign elig0 = req0 & ~gnt0_q;
  assign elig1 = req1 & ~gnt1_q;

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
  // 1: requester 1 won the most recent grant. Reset value makes requester 0
  // win the first tie.
  logic last_q, last_d;
  assign pick0 = elig0 & (~elig1 | last_q);
`else
  assign pick0 = elig0;
`endif
  assign pick1 = elig1 & ~pick0;

  // Next-state and next-output computation for the clear/arbitrate FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    we3_d   = 1'b0;
    wa3_d   = wa3_q;
    wd3_d   = wd3_q;
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    case (state_q)
      ST_CLEAR: begin
        we3_d  = 1'b1;
        wa3_d  = cnt_q;
        wd3_d  = '0;
        cnt_d  = cnt_q + ADDR_W'(1);
        busy_d = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_ARB;
        end
      end
      ST_ARB: begin
        busy_d = 1'b0;
        if (clr_req) begin
          // Entry cycle: no write this edge, the first zero-write follows.
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_CLEAR;
        end else if (pick0) begin
          gnt0_d = 1'b1;
          we3_d  = 1'b1;
          wa3_d  = addr0;
          wd3_d  = data0;
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
          last_d = 1'b0;
`endif
        end else if (pick1) begin
          gnt1_d = 1'b1;
          we3_d  = 1'b1;
          wa3_d  = addr1;
          wd3_d  = data1;
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
          last_d = 1'b1;
`endif
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset starts a fresh clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      we3_q   <= 1'b0;
      wa3_q   <= '0;
      wd3_q   <= '0;
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      we3_q   <= we3_d;
      wa3_q   <= wa3_d;
      wd3_q   <= wd3_d;
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;
  assign busy = busy_q;
  assign we3  = we3_q;
  assign wa3  = wa3_q;
  assign wd3  = wd3_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed, table-driven bench for regfile_write_arbiter.
module tb_regfile_write_arbiter;

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       req0, req1, clr_req;
  logic [2:0] addr0, addr1;
  logic [7:0] data0, data1;
  logic       gnt0, gnt1, busy, we3;
  logic [2:0] wa3;
  logic [7:0] wd3;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [8];

  regfile_write_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .data0(data0), .gnt0(gnt0),
    .req1(req1), .addr1(addr1), .data1(data1), .gnt1(gnt1),
    .clr_req(clr_req), .busy(busy),
    .wa3(wa3), .wd3(wd3), .we3(we3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register bank fed by the write port.
  always @(posedge clk) begin
    if (rst && we3) mem[wa3] <= wd3;
  end

  typedef struct {
    logic       r0;
    logic [2:0] a0;
    logic [7:0] d0;
    logic       r1;
    logic [2:0] a1;
    logic [7:0] d1;
    logic       clr;
    logic       g0, g1, we, bz;
    logic [2:0] wa;
    logic [7:0] wd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r0, logic [2:0] a0, logic [7:0] d0,
                              logic r1, logic [2:0] a1, logic [7:0] d1,
                              logic clr, logic g0, logic g1, logic we,
                              logic bz, logic [2:0] wa, logic [7:0] wd);
    vec_t v;
    v.r0 = r0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.a1 = a1; v.d1 = d1;
    v.clr = clr;
    v.g0 = g0; v.g1 = g1; v.we = we; v.bz = bz; v.wa = wa; v.wd = wd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic eg0, input logic eg1,
                           input logic ewe, input logic ebz,
                           input logic [2:0] ewa, input logic [7:0] ewd);
    chk({tag, ".gnt0"}, {31'd0, gnt0}, {31'd0, eg0});
    chk({tag, ".gnt1"}, {31'd0, gnt1}, {31'd0, eg1});
    chk({tag, ".we3"},  {31'd0, we3},  {31'd0, ewe});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, ebz});
    chk({tag, ".both_gnt"}, {31'd0, gnt0 & gnt1}, 32'd0);
    if (ewe) begin
      chk({tag, ".wa3"}, {29'd0, wa3}, {29'd0, ewa});
      chk({tag, ".wd3"}, {24'd0, wd3}, {24'd0, ewd});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    req0 = v.r0; addr0 = v.a0; data0 = v.d0;
    req1 = v.r1; addr1 = v.a1; data1 = v.d1;
    clr_req = v.clr;
  endtask

  task automatic idle_inputs();
    req0 = 0; addr0 = 0; data0 = 0;
    req1 = 0; addr1 = 0; data1 = 0;
    clr_req = 0;
  endtask

  task automatic check_clear(input string tag, input int first);
    for (int i = first; i < 8; i++) begin
      step();
      check_out($sformatf("%s_clr%0d", tag, i), 0, 0, 1, 1, 3'(i), 8'h00);
    end
  endtask

  initial begin
    // Vector table: inputs applied before an edge, outputs expected after it.
    vecs.push_back(mk(1, 5, 8'hA5, 0, 0, 8'h00, 0, 1, 0, 1, 0, 5, 8'hA5));
    vecs.push_back(mk(0, 5, 8'hA5, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00));
    // Both held: requester 0 was the last winner, so round-robin starts with 1.
    for (int k = 0; k < 6; k++) begin
      logic w;
      w = RR ^ (k % 2 == 1);
      vecs.push_back(mk(1, 1, 8'h11, 1, 2, 8'h22, 0, ~w, w, 1, 0,
                        w ? 3'd2 : 3'd1, w ? 8'h22 : 8'h11));
    end
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00));
    // req0 held alone: masked every other cycle.
    for (int k = 0; k < 4; k++) begin
      vecs.push_back(mk(1, 3, 8'h33, 0, 0, 8'h00, 0, (k % 2 == 0), 0,
                        (k % 2 == 0), 0, 3, 8'h33));
    end
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 0, 8'h00, 1, 7, 8'h77, 0, 0, 1, 1, 0, 7, 8'h77));

    for (int i = 0; i < 8; i++) mem[i] = 8'hFF;

    // Reset state.
    rst = 1'b0;
    idle_inputs();
    #12;
    check_out("reset", 0, 0, 0, 1, 0, 8'h00);
    chk("reset.wa3", {29'd0, wa3}, 32'd0);
    chk("reset.wd3", {24'd0, wd3}, 32'd0);

    // Clear after reset: edges 0..7, then first arbitration at edge 8.
    @(negedge clk);
    rst = 1'b1;
    check_clear("init", 0);
    step();
    check_out("init_end", 0, 0, 0, 0, 0, 8'h00);
    chk("init_mem0", {24'd0, mem[0]}, 32'd0);

    // Table-driven main sequence.
    foreach (vecs[i]) begin
      drive(vecs[i]);
      step();
      check_out($sformatf("vec%0d", i), vecs[i].g0, vecs[i].g1, vecs[i].we,
                vecs[i].bz, vecs[i].wa, vecs[i].wd);
    end
    chk("mem5_readback", {24'd0, mem[5]}, 32'hA5);
    chk("mem3_readback", {24'd0, mem[3]}, 32'h33);

    // clr_req in ARB while req1 is pending.
    req0 = 0; req1 = 1; addr1 = 6; data1 = 8'h66; clr_req = 1;
    step();
    check_out("clr_entry", 0, 0, 0, 1, 0, 8'h00);
    clr_req = 0;
    check_clear("clr", 0);
    step();
    check_out("clr_after", 0, 1, 1, 0, 6, 8'h66);
    chk("clr_mem5", {24'd0, mem[5]}, 32'd0);
    req1 = 0;
    step();
    check_out("clr_drop", 0, 0, 0, 0, 0, 8'h00);
    chk("clr_mem6", {24'd0, mem[6]}, 32'h66);

    // Reset asserted mid-clear at address 3.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_out("rst2", 0, 0, 0, 1, 0, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_out($sformatf("pre_clr%0d", i), 0, 0, 1, 1, 3'(i), 8'h00);
    end
    #2;
    rst = 1'b0;
    #1;
    check_out("rst_mid", 0, 0, 0, 1, 0, 8'h00);
    chk("rst_mid.wa3", {29'd0, wa3}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    check_clear("restart", 0);
    step();
    check_out("restart_end", 0, 0, 0, 0, 0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
